// File: rtl/bicycle_pkg.sv
// Shared constants for the bicycle controller button front end and its benches.
// Channel indices map each raw button onto its bicycle_fsm input.
package bicycle_pkg;

  localparam int NUM_BUTTONS = 3;

  localparam int BTN_FASTER = 0;
  localparam int BTN_SLOWER = 1;
  localparam int BTN_NEXT   = 2;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int REPEAT_CYCLES_DEF   = 64;

  typedef enum logic {
    BTN_RELEASED = 1'b0,
    BTN_HELD     = 1'b1
  } btn_state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop sync, debounce, press pulse; auto-repeat if BICYCLE_AUTOREPEAT_EN.
// Press-to-pulse DEBOUNCE_CYCLES+1 edges after first sample; no backpressure, pulses never merge.
module button_debounce
  import bicycle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          flip;
  btn_state_e    state_q;
  logic          pulse_q;

  // Any sample matching the debounced level restarts the mismatch count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    flip  = 1'b0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        flip = 1'b1;
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef BICYCLE_AUTOREPEAT_EN
  localparam int            RW      = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_q;
  logic          rep_done;

  assign rep_done = (rep_q == REP_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_q <= '0;
    end else if (state_q == BTN_RELEASED || flip || rep_done) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_q + 1'b1;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_CYCLES < 2);
`endif

  // State mirrors db; a rising flip while RELEASED is the only press event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BTN_RELEASED;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        BTN_RELEASED: begin
          if (flip) begin
            state_q <= BTN_HELD;
            pulse_q <= 1'b1;
          end
        end
        BTN_HELD: begin
          if (flip) begin
            state_q <= BTN_RELEASED;
          end
`ifdef BICYCLE_AUTOREPEAT_EN
          else if (rep_done) begin
            pulse_q <= 1'b1;
          end
`endif
        end
      endcase
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/bicycle_button_conditioner.sv
// Conditions the faster/slower/next buttons into one-cycle pulses for bicycle_fsm.
// Latency DEBOUNCE_CYCLES+1 edges per press; no backpressure; BICYCLE_AUTOREPEAT_EN adds repeats.
module bicycle_button_conditioner
  import bicycle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic faster_raw,
  input  logic slower_raw,
  input  logic next_raw,
  output logic faster,
  output logic slower,
  output logic next
);

  logic [NUM_BUTTONS-1:0] raw_vec;
  logic [NUM_BUTTONS-1:0] pulse_vec;

  assign raw_vec[BTN_FASTER] = faster_raw;
  assign raw_vec[BTN_SLOWER] = slower_raw;
  assign raw_vec[BTN_NEXT]   = next_raw;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_btn (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw_vec[i]),
      .pulse  (pulse_vec[i])
    );
  end

  assign faster = pulse_vec[BTN_FASTER];
  assign slower = pulse_vec[BTN_SLOWER];
  assign next   = pulse_vec[BTN_NEXT];

endmodule

// File: tb/tb_bicycle_button_conditioner.sv
// Bench for bicycle_button_conditioner: directed scenarios with literal pulse times,
// then randomized presses/bounces/resets checked every cycle against a windowed model.
module tb_bicycle_button_conditioner;
  import bicycle_pkg::*;

  localparam int DB = 4;
  localparam int RP = 8;

  logic clk        = 1'b0;
  logic reset_n    = 1'b0;
  logic faster_raw = 1'b0;
  logic slower_raw = 1'b0;
  logic next_raw   = 1'b0;
  logic faster;
  logic slower;
  logic next;

  int checks = 0;
  int errors = 0;

  bicycle_button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .faster_raw(faster_raw),
    .slower_raw(slower_raw),
    .next_raw  (next_raw),
    .faster    (faster),
    .slower    (slower),
    .next      (next)
  );

  always #5 clk = ~clk;

  // Model: a press is accepted once the last DB synchronized samples all disagree
  // with the accepted level; samples reach the debouncer two edges after capture.
  bit m_s1   [NUM_BUTTONS];
  bit m_s2   [NUM_BUTTONS];
  bit m_db   [NUM_BUTTONS];
  bit m_exp  [NUM_BUTTONS];
  bit m_hist [NUM_BUTTONS][$];
  int m_last [NUM_BUTTONS];
  int log_q  [NUM_BUTTONS][$];
  int edge_cnt = 0;
  int t0       = 0;
  string ch_name [NUM_BUTTONS] = '{"faster", "slower", "next"};

  function automatic bit raw_of(input int ch);
    case (ch)
      BTN_FASTER: return faster_raw;
      BTN_SLOWER: return slower_raw;
      default:    return next_raw;
    endcase
  endfunction

  function automatic bit dut_of(input int ch);
    case (ch)
      BTN_FASTER: return faster;
      BTN_SLOWER: return slower;
      default:    return next;
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void model_step(input int cur);
    for (int ch = 0; ch < NUM_BUTTONS; ch++) begin
      bit seen;
      bit all_diff;
      m_exp[ch] = 1'b0;
      if (!reset_n) begin
        m_s1[ch] = 1'b0;
        m_s2[ch] = 1'b0;
        m_db[ch] = 1'b0;
        m_hist[ch].delete();
        continue;
      end
      seen     = m_s2[ch];
      m_s2[ch] = m_s1[ch];
      m_s1[ch] = raw_of(ch);
      m_hist[ch].push_back(seen);
      if (m_hist[ch].size() > DB) void'(m_hist[ch].pop_front());
      all_diff = (m_hist[ch].size() == DB);
      for (int i = 0; i < m_hist[ch].size(); i++)
        if (m_hist[ch][i] == m_db[ch]) all_diff = 1'b0;
      if (all_diff) begin
        m_db[ch] = !m_db[ch];
        if (m_db[ch]) begin
          m_exp[ch]  = 1'b1;
          m_last[ch] = cur;
        end
      end
`ifdef BICYCLE_AUTOREPEAT_EN
      else if (m_db[ch] && (cur - m_last[ch] == RP)) begin
        m_exp[ch]  = 1'b1;
        m_last[ch] = cur;
      end
`endif
    end
  endfunction

  task automatic step();
    int cur;
    @(posedge clk);
    cur = edge_cnt;
    edge_cnt++;
    model_step(cur);
    @(negedge clk);
    for (int ch = 0; ch < NUM_BUTTONS; ch++) begin
      chk($sformatf("%s@edge%0d", ch_name[ch], cur), dut_of(ch), m_exp[ch]);
      if (dut_of(ch)) log_q[ch].push_back(cur - t0);
    end
  endtask

  task automatic begin_scn();
    t0 = edge_cnt;
    for (int ch = 0; ch < NUM_BUTTONS; ch++) log_q[ch].delete();
  endtask

  task automatic idle(input int n);
    faster_raw = 1'b0;
    slower_raw = 1'b0;
    next_raw   = 1'b0;
    repeat (n) step();
  endtask

  task automatic chk_log(input string name, input int ch, input int exp[$]);
    chk({name, " pulse count"}, log_q[ch].size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < log_q[ch].size())
        chk($sformatf("%s pulse%0d edge", name, i), log_q[ch][i], exp[i]);
  endtask

  initial begin
    int e[$];
    int none[$];
    bit bounce[5];
    int p;
    none = {};

    // Reset with outputs held low.
    reset_n = 1'b0;
    repeat (3) begin
      step();
      chk("reset faster", faster, 0);
      chk("reset slower", slower, 0);
      chk("reset next", next, 0);
    end
    reset_n = 1'b1;
    idle(5);

    // Clean press held 20 cycles.
    begin_scn();
    faster_raw = 1'b1;
    repeat (20) step();
    idle(12);
    e = {};
    e.push_back(5);
`ifdef BICYCLE_AUTOREPEAT_EN
    e.push_back(13);
    e.push_back(21);
`endif
    chk_log("clean faster", BTN_FASTER, e);
    chk_log("clean slower", BTN_SLOWER, none);
    chk_log("clean next", BTN_NEXT, none);

    // Bounce 1,0,1,1,0 then stable high from edge 5 through edge 11.
    begin_scn();
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      slower_raw = bounce[i];
      step();
    end
    slower_raw = 1'b1;
    repeat (7) step();
    idle(12);
    e = {};
    e.push_back(10);
    chk_log("bounce slower", BTN_SLOWER, e);
    chk_log("bounce faster", BTN_FASTER, none);

    // Three-sample glitch never accepted.
    begin_scn();
    next_raw = 1'b1;
    repeat (3) step();
    idle(12);
    chk_log("glitch next", BTN_NEXT, none);

    // Simultaneous faster/slower press.
    begin_scn();
    faster_raw = 1'b1;
    slower_raw = 1'b1;
    repeat (7) step();
    idle(12);
    e = {};
    e.push_back(5);
    chk_log("simul faster", BTN_FASTER, e);
    chk_log("simul slower", BTN_SLOWER, e);
    chk_log("simul next", BTN_NEXT, none);

    // Reset two cycles into a debounce, button still held across release.
    begin_scn();
    faster_raw = 1'b1;
    repeat (2) step();
    reset_n = 1'b0;
    repeat (3) begin
      step();
      chk("midreset faster", faster, 0);
      chk("midreset slower", slower, 0);
      chk("midreset next", next, 0);
    end
    chk_log("pre-release faster", BTN_FASTER, none);
    reset_n = 1'b1;
    begin_scn();
    repeat (7) step();
    idle(12);
    e = {};
    e.push_back(5);
    chk_log("postreset faster", BTN_FASTER, e);

    // Long hold of next for 30 cycles.
    begin_scn();
    next_raw = 1'b1;
    repeat (30) step();
    idle(20);
    e = {};
    e.push_back(5);
`ifdef BICYCLE_AUTOREPEAT_EN
    e.push_back(13);
    e.push_back(21);
    e.push_back(29);
`endif
    chk_log("hold next", BTN_NEXT, e);

    // Randomized presses, bounce bursts and occasional resets.
    for (int blk = 0; blk < 24; blk++) begin
      p = ($urandom_range(0, 1) == 0) ? 3 : 25;
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(0, p - 1) == 0) faster_raw = ~faster_raw;
        if ($urandom_range(0, p - 1) == 0) slower_raw = ~slower_raw;
        if ($urandom_range(0, p - 1) == 0) next_raw   = ~next_raw;
        if (!reset_n) reset_n = ($urandom_range(0, 1) == 1);
        else if ($urandom_range(0, 399) == 0) reset_n = 1'b0;
        step();
      end
    end
    reset_n = 1'b1;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
